ising_energy_readout: RTL and testbench

ISING_ENERGY_READOUT -- requirements
Module: ising_energy_readout

---
 rtl/ising_energy_readout_if.sv | 26 ++
 rtl/ising_energy_readout.sv | 122 ++++++++++++
 tb/tb_ising_energy_readout.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ising_energy_readout_if.sv
// Bundle of the request/result signals for ising_energy_readout.
// The requester uses the master modport and the readout engine uses the slave modport.
interface ising_energy_readout_if #(
  parameter int N         = 16,
  parameter int dataWidth = 32
);
  localparam int ENERGY_W = (N > 1) ? dataWidth + 2 * $clog2(N) : dataWidth + 1;

  logic                        start;
  logic signed [dataWidth-1:0] phases         [N-1:0];
  logic signed [dataWidth-1:0] couplingMatrix [N-1:0][N-1:0];
  logic [N-1:0]                spins;
  logic signed [ENERGY_W-1:0]  energy;
  logic                        busy;
  logic                        done;

  modport master (
    output start, phases, couplingMatrix,
    input  spins, energy, busy, done
  );

  modport slave (
    input  start, phases, couplingMatrix,
    output spins, energy, busy, done
  );
endinterface

// File: rtl/ising_energy_readout.sv
// Converts final oscillator phases to Ising spins, then accumulates
// E = -sum_{i<j} J_ij s_i s_j one upper-triangle pair per clock.
module ising_energy_readout #(
  parameter int N              = 16,
  parameter int fractionalBits = 16,
  parameter int dataWidth      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ising_energy_readout_if.slave bus
);
  localparam int ENERGY_W = (N > 1) ? dataWidth + 2 * $clog2(N) : dataWidth + 1;
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = real'(longint'(1) << fractionalBits);
  localparam logic signed [dataWidth-1:0] PI_HALF =
    dataWidth'($rtoi(PI / 2.0 * SCALE + 0.5));
  localparam logic signed [dataWidth-1:0] THREE_PI_HALF =
    dataWidth'($rtoi(3.0 * PI / 2.0 * SCALE + 0.5));

  typedef enum logic [1:0] {IDLE, BINARIZE, ACCUM, DONE} state_e;

  state_e                      state_q, state_d;
  logic signed [dataWidth-1:0] phase_q [N-1:0];
  logic signed [dataWidth-1:0] phase_d [N-1:0];
  logic [N-1:0]                spins_q, spins_d;
  logic signed [ENERGY_W-1:0]  acc_q, acc_d;
  logic signed [ENERGY_W-1:0]  energy_q, energy_d;
  logic [IDX_W-1:0]            i_q, i_d, j_q, j_d;
  logic signed [dataWidth-1:0] coup;
  logic signed [ENERGY_W-1:0]  coup_ext;
  logic                        last_pair;
  logic                        busy, done;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    spins_d   = spins_q;
    acc_d     = acc_q;
    energy_d  = energy_q;
    i_d       = i_q;
    j_d       = j_q;
    busy      = 1'b0;
    done      = 1'b0;
    coup      = bus.couplingMatrix[i_q][j_q];
    coup_ext  = {{(ENERGY_W - dataWidth){coup[dataWidth-1]}}, coup};
    last_pair = (i_q == IDX_W'(N - 2)) && (j_q == IDX_W'(N - 1));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          phase_d = bus.phases;
          state_d = BINARIZE;
        end
      end
      BINARIZE: begin
        busy = 1'b1;
        // +1 covers [-pi/2, pi/2) plus the wrapped-around band at and above 3pi/2
        for (int unsigned k = 0; k < N; k++) begin
          spins_d[k[IDX_W-1:0]] =
            ((phase_q[k[IDX_W-1:0]] >= -PI_HALF) && (phase_q[k[IDX_W-1:0]] < PI_HALF)) ||
            (phase_q[k[IDX_W-1:0]] >= THREE_PI_HALF);
        end
        acc_d = '0;
        i_d   = '0;
        j_d   = IDX_W'(1);
        if (N == 1) begin
          energy_d = '0;
          state_d  = DONE;
        end else begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        busy  = 1'b1;
        acc_d = (spins_q[i_q] != spins_q[j_q]) ? acc_q + coup_ext : acc_q - coup_ext;
        if (last_pair) begin
          energy_d = acc_d;
          state_d  = DONE;
        end else if (j_q == IDX_W'(N - 1)) begin
          i_d = i_q + IDX_W'(1);
          j_d = i_q + IDX_W'(2);
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      spins_q  <= '0;
      acc_q    <= '0;
      energy_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        phase_q[k[IDX_W-1:0]] <= '0;
      end
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      spins_q  <= spins_d;
      acc_q    <= acc_d;
      energy_q <= energy_d;
      i_q      <= i_d;
      j_q      <= j_d;
    end
  end

  assign bus.spins  = spins_q;
  assign bus.energy = energy_q;
  assign bus.busy   = busy;
  assign bus.done   = done;
endmodule

// File: tb/tb_ising_energy_readout.sv
// Self-checking bench for ising_energy_readout (N=4, 16 fractional bits):
// directed cases plus randomized phases/couplings against a behavioural energy model.
module tb_ising_energy_readout;
  localparam int N  = 4;
  localparam int FB = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  ising_energy_readout_if #(.N(N), .dataWidth(DW)) bus ();

  ising_energy_readout #(
    .N(N),
    .fractionalBits(FB),
    .dataWidth(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ph [N];
  int jm [N][N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Spin +1 on [-pi/2, pi/2) or at/above 3pi/2 (constants rounded to 16 fractional bits)
  function automatic int ref_spin(input int p);
    return ((p >= -102944 && p < 102944) || p >= 308831) ? 1 : -1;
  endfunction

  function automatic logic [N-1:0] ref_spins();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (ref_spin(ph[i]) == 1);
    return r;
  endfunction

  function automatic longint ref_energy();
    longint e = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        e -= longint'(jm[i][j]) * ref_spin(ph[i]) * ref_spin(ph[j]);
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.phases[i] = ph[i];
      for (int j = 0; j < N; j++) bus.couplingMatrix[i][j] = jm[i][j];
    end
  endtask

  task automatic set_all(input int p, input int c);
    for (int i = 0; i < N; i++) begin
      ph[i] = p;
      for (int j = 0; j < N; j++) jm[i][j] = c;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
  endtask

  // One full request; optionally re-pulse start while the engine is accumulating.
  task automatic run_op(input string tag, input bit repulse);
    int cyc;
    int busy_bad;
    int pulses;
    logic [N-1:0] es;
    longint ee;
    es = ref_spins();
    ee = ref_energy();
    drive_inputs();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    busy_bad = 0;
    while (!bus.done && cyc < 40) begin
      if (!bus.busy) busy_bad++;
      bus.start = repulse && (cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busy_window"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_spins"}, bus.spins, es);
    check({tag, "_energy"}, longint'(bus.energy), ee);
    @(posedge clk); #1;
    check({tag, "_done_single"}, bus.done, 0);
    check({tag, "_energy_hold"}, longint'(bus.energy), ee);
    check({tag, "_spins_hold"}, bus.spins, es);
    if (repulse) begin
      count_done(12, pulses);
      check({tag, "_no_extra_done"}, pulses, 0);
    end
  endtask

  function automatic int rand_phase();
    int bnd [6] = '{-102945, -102944, 102943, 102944, 308830, 308831};
    if ($urandom_range(0, 3) == 0) return bnd[$urandom_range(0, 5)];
    return int'($urandom_range(0, 823550)) - 411775;
  endfunction

  initial begin
    int pulses;
    rst = 1'b1;
    bus.start = 1'b0;
    set_all(0, 0);
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_spins", bus.spins, 0);
    check("reset_energy", longint'(bus.energy), 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;

    set_all(0, 65536);
    run_op("all_aligned", 1'b0);

    set_all(65536, 65536);
    ph[0] = 0; ph[1] = 205887; ph[2] = 0; ph[3] = 205887;
    run_op("alternating", 1'b0);

    ph[0] = 102943; ph[1] = 102944; ph[2] = 308830; ph[3] = 308831;
    run_op("boundary", 1'b0);

    set_all(0, 65536);
    jm[0][1] = 7 * 65536; jm[2][3] = -3 * 65536;
    run_op("repulse", 1'b1);

    set_all(0, 0);
    jm[0][1] = -65536; jm[1][0] = 999999;
    jm[0][0] = 12345; jm[3][3] = -777; jm[3][1] = 55555;
    run_op("upper_only", 1'b0);

    // Abort mid-accumulation with a coincident start that must be ignored
    set_all(0, 65536);
    drive_inputs();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_spins", bus.spins, 0);
    check("abort_energy", longint'(bus.energy), 0);
    count_done(12, pulses);
    check("abort_no_done", pulses, 0);
    ph[1] = 205887;
    run_op("after_abort", 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        ph[i] = rand_phase();
        for (int j = 0; j < N; j++) jm[i][j] = int'($urandom_range(0, 2097152)) - 1048576;
      end
      run_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
